// File: rtl/mandelbrot_pixel_sequencer.sv
// Mandelbrot pixel sequencer.
// Walks the screen raster one pixel at a time, hands each coordinate to a
// free-running iteration engine, waits for the engine's done pulse, captures
// the colour that follows it and issues one framebuffer write per pixel in
// strict raster order. One frame is produced per i_start.
module mandelbrot_pixel_sequencer #(
  parameter int H_RES  = 800,
  parameter int V_RES  = 600,
  parameter int ADDR_W = 19
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic signed [15:0]  o_x,
  output logic signed [15:0]  o_y,
  input  logic                i_done,
  input  logic [7:0]          i_red,
  input  logic [7:0]          i_green,
  input  logic [7:0]          i_blue,
  output logic                o_wr_valid,
  input  logic                i_wr_ready,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [23:0]         o_wr_data,
  output logic                o_busy,
  output logic                o_frame_done
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_pendAddr;
  logic                r_capture;
  logic                r_wrValid;
  logic [ADDR_W-1:0]   r_wrAddr;
  logic [23:0]         r_wrData;
  logic                r_frameDone;

  logic                w_handshake;
  logic                w_bufFree;
  logic                w_accept;
  logic                w_lastPixel;
  logic                w_drainDone;
  logic [ADDR_W-1:0]   w_pixelAddr;

  // The write slot can take a new result when it is empty or is being
  // emptied on this very edge. A done arriving during the capture cycle is
  // treated like a busy slot so the pending address is never overwritten.
  assign w_handshake = r_wrValid & i_wr_ready;
  assign w_bufFree   = ~r_wrValid | i_wr_ready;
  assign w_accept    = (r_state == ST_RUN) & i_done & w_bufFree & ~r_capture;
  assign w_lastPixel = (r_x == X_LAST) & (r_y == Y_LAST);
  assign w_drainDone = (r_state == ST_DRAIN) & w_handshake & ~r_capture;
  assign w_pixelAddr = ADDR_W'(r_y) * ADDR_W'(H_RES) + ADDR_W'(r_x);

  // State register for the frame controller.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: FLUSH swallows the engine's stale result, RUN accepts
  // pixels, DRAIN waits for the last write to be taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_nextState = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_done) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && w_lastPixel) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drainDone) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Raster coordinate: only moves when a result is accepted, so a dropped
  // result makes the engine recompute the same pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == ST_IDLE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        if (r_y == Y_LAST) begin
          r_y <= '0;
        end else begin
          r_y <= r_y + Y_W'(1);
        end
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  // Remember which pixel was accepted; its colour arrives one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_capture  <= 1'b0;
      r_pendAddr <= '0;
    end else begin
      r_capture <= w_accept;
      if (w_accept) begin
        r_pendAddr <= w_pixelAddr;
      end
    end
  end

  // Single-entry write slot: loaded on the capture cycle, held until taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
    end else if (r_capture) begin
      r_wrValid <= 1'b1;
      r_wrAddr  <= r_pendAddr;
      r_wrData  <= {i_red, i_green, i_blue};
    end else if (w_handshake) begin
      r_wrValid <= 1'b0;
    end
  end

  // One-cycle end-of-frame pulse on the edge that takes the final write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_drainDone;
    end
  end

  assign o_x          = 16'(r_x);
  assign o_y          = 16'(r_y);
  assign o_wr_valid   = r_wrValid;
  assign o_wr_addr    = r_wrAddr;
  assign o_wr_data    = r_wrData;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_mandelbrot_pixel_sequencer.sv
// Bench for the Mandelbrot pixel sequencer on a 4x3 screen.
// A behavioural engine answers each coordinate after a random latency and a
// scoreboard expects every frame as addresses 0..11 in order carrying the
// colour the engine gives for (addr % 4, addr / 4).
module tb_mandelbrot_pixel_sequencer;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int AW   = 4;
  localparam int NPIX = H * V;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               done;
  logic               ready;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;
  logic signed [15:0] ox;
  logic signed [15:0] oy;
  logic               wrValid;
  logic [AW-1:0]      wrAddr;
  logic [23:0]        wrData;
  logic               busy;
  logic               frameDone;

  int vectors     = 0;
  int miscompares = 0;
  int colourSeed  = 0;
  int engMinLat   = 2;
  int engMaxLat   = 5;
  int flushReqCnt = 0;
  int writesTotal = 0;
  int framesDone  = 0;
  int engPhase    = 0;
  int engCnt      = 0;
  int engX        = 0;
  int engY        = 0;

  mandelbrot_pixel_sequencer #(
    .H_RES  (H),
    .V_RES  (V),
    .ADDR_W (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_x          (ox),
    .o_y          (oy),
    .i_done       (done),
    .i_red        (red),
    .i_green      (green),
    .i_blue       (blue),
    .o_wr_valid   (wrValid),
    .i_wr_ready   (ready),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_busy       (busy),
    .o_frame_done (frameDone)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Colour the engine reports for a pixel; the seed makes frames differ.
  function automatic logic [23:0] colourOf(input int x, input int y, input int seed);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = 8'((x * 53 + y * 29 + seed) & 255);
    g = 8'(((x * 7) ^ (y * 91) ^ seed) & 255);
    b = 8'(((x + y * 4) * 13 + seed * 3) & 255);
    return {r, g, b};
  endfunction

  // Engine model: sample coordinate, compute for a random time, pulse done
  // with the colour, keep the colour one more cycle, then sample again.
  task automatic engineLoop();
    int seenFlush;
    logic [23:0] c;
    seenFlush = 0;
    forever begin
      @(negedge clk);
      if (flushReqCnt != seenFlush) begin
        seenFlush = flushReqCnt;
        engX      = 2;
        engY      = 1;
        engCnt    = 3;
        engPhase  = 1;
        done      = 1'b0;
      end else begin
        case (engPhase)
          0: begin
            engX     = int'(ox);
            engY     = int'(oy);
            engCnt   = int'($urandom_range(engMaxLat, engMinLat));
            engPhase = 1;
          end
          1: begin
            if (engCnt > 1) begin
              engCnt--;
            end else begin
              c        = colourOf(engX, engY, colourSeed);
              red      = c[23:16];
              green    = c[15:8];
              blue     = c[7:0];
              done     = 1'b1;
              engPhase = 2;
            end
          end
          default: begin
            done     = 1'b0;
            engPhase = 0;
          end
        endcase
      end
    end
  endtask

  // Scoreboard: every accepted write must be the next raster pixel with its
  // colour, a pending write must hold still, and the frame-done pulse must
  // follow exactly the final write.
  task automatic monitorLoop();
    int          expNext;
    bit          lastFinal;
    bit          hs;
    bit          heldValid;
    logic [AW-1:0] heldAddr;
    logic [23:0] heldData;
    logic [23:0] expData;
    expNext   = 0;
    lastFinal = 1'b0;
    heldValid = 1'b0;
    heldAddr  = '0;
    heldData  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        expNext   = 0;
        lastFinal = 1'b0;
        heldValid = 1'b0;
      end else begin
        vectors++;
        if (frameDone !== lastFinal) begin
          miscompares++;
          $display("[TB] FAIL frame_done_pulse: got %b expected %b at %0t", frameDone, lastFinal, $time);
        end
        if (lastFinal) framesDone++;
        if (heldValid) begin
          vectors++;
          if (wrValid !== 1'b1 || wrAddr !== heldAddr || wrData !== heldData) begin
            miscompares++;
            $display("[TB] FAIL write_hold: got valid=%b addr=%0d data=%h expected valid=1 addr=%0d data=%h at %0t",
                     wrValid, wrAddr, wrData, heldAddr, heldData, $time);
          end
        end
        hs        = (wrValid === 1'b1) && (ready === 1'b1);
        lastFinal = 1'b0;
        if (hs) begin
          expData = colourOf(expNext % H, expNext / H, colourSeed);
          vectors++;
          if (wrAddr !== AW'(expNext) || wrData !== expData) begin
            miscompares++;
            $display("[TB] FAIL write_order: got addr=%0d data=%h expected addr=%0d data=%h at %0t",
                     wrAddr, wrData, expNext, expData, $time);
          end
          writesTotal++;
          if (expNext == NPIX - 1) begin
            lastFinal = 1'b1;
            expNext   = 0;
          end else begin
            expNext++;
          end
        end
        heldValid = (wrValid === 1'b1) && !hs;
        heldAddr  = wrAddr;
        heldData  = wrData;
      end
    end
  endtask

  // Advance n clock cycles, landing 1 time unit after the rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  // Reset values, then an asynchronous reset while a write is pending.
  task automatic test_reset();
    bit got;
    int bad;
    cycles(3);
    vectors++;
    if ({ox, oy, wrValid, wrAddr, wrData, busy, frameDone} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got x=%0d y=%0d valid=%b addr=%0d data=%h busy=%b fd=%b expected all zero",
               ox, oy, wrValid, wrAddr, wrData, busy, frameDone);
    end
    rst_n = 1'b1;
    cycles(2);
    colourSeed = 17;
    ready      = 1'b0;
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (wrValid === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL reset_pending_timeout: got no pending write expected one within 300 cycles");
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ox, oy, wrValid, wrAddr, wrData, busy, frameDone} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got x=%0d y=%0d valid=%b addr=%0d data=%h busy=%b fd=%b expected all zero",
               ox, oy, wrValid, wrAddr, wrData, busy, frameDone);
    end
    cycles(2);
    rst_n = 1'b1;
    ready = 1'b1;
    bad   = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (wrValid !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_after: got %0d cycles with write or busy expected 0", bad);
    end
  endtask

  // Clean frame with the framebuffer always ready.
  task automatic test_full_frame();
    bit got;
    int w0;
    int f0;
    colourSeed = 101;
    ready      = 1'b1;
    w0 = writesTotal;
    f0 = framesDone;
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (frameDone === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL full_frame_timeout: got no frame_done expected one within 2000 cycles");
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_frame_busy: got busy=%b expected 0 with frame_done", busy);
    end
    cycles(1);
    vectors++;
    if (frameDone !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_frame_pulse_width: got frame_done=%b expected 0", frameDone);
    end
    cycles(1);
    vectors++;
    if (writesTotal - w0 != NPIX || framesDone - f0 != 1) begin
      miscompares++;
      $display("[TB] FAIL full_frame_count: got writes=%0d frames=%0d expected writes=%0d frames=1",
               writesTotal - w0, framesDone - f0, NPIX);
    end
  endtask

  // Engine is mid-way on a stale pixel (2,1) when the frame starts.
  task automatic test_flush();
    bit got;
    colourSeed = 55;
    ready      = 1'b1;
    flushReqCnt++;
    cycles(1);
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (wrValid === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got || wrAddr !== AW'(0) || wrData !== colourOf(0, 0, colourSeed)) begin
      miscompares++;
      $display("[TB] FAIL flush_first_write: got found=%b addr=%0d data=%h expected addr=0 data=%h",
               got, wrAddr, wrData, colourOf(0, 0, colourSeed));
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (frameDone === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL flush_frame_timeout: got no frame_done expected one within 2000 cycles");
    end
    cycles(2);
  endtask

  // Stall the framebuffer on address 5; coordinate must stay on (2,1).
  task automatic test_backpressure();
    bit got;
    int bad;
    int doneSeen;
    colourSeed = 203;
    engMinLat  = 2;
    engMaxLat  = 2;
    ready      = 1'b1;
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (wrValid === 1'b1 && wrAddr === AW'(5)) got = 1'b1;
      else cycles(1);
    end
    ready = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL bp_reach_addr5: got no write of addr 5 expected one within 2000 cycles");
    end
    bad      = 0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (done === 1'b1) doneSeen++;
      if (ox !== 16'sd2 || oy !== 16'sd1 || wrValid !== 1'b1 || wrAddr !== AW'(5)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got %0d cycles off (x=%0d y=%0d valid=%b addr=%0d) expected 0 at (2,1) addr 5",
               bad, ox, oy, wrValid, wrAddr);
    end
    vectors++;
    if (doneSeen == 0) begin
      miscompares++;
      $display("[TB] FAIL bp_done_events: got %0d done pulses during stall expected at least 1", doneSeen);
    end
    ready = 1'b1;
    cycles(1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (wrValid === 1'b1 && wrAddr !== AW'(5)) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got || wrAddr !== AW'(6)) begin
      miscompares++;
      $display("[TB] FAIL bp_next_addr: got found=%b addr=%0d expected addr=6", got, wrAddr);
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (frameDone === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL bp_frame_timeout: got no frame_done expected one within 2000 cycles");
    end
    engMinLat = 2;
    engMaxLat = 5;
    cycles(2);
  endtask

  // Engine done lands on the handshake edge of address 3; i_start mid-run.
  task automatic test_simultaneous();
    bit got;
    int w0;
    int f0;
    int bad;
    colourSeed = 77;
    engMinLat  = 3;
    engMaxLat  = 5;
    ready      = 1'b1;
    w0 = writesTotal;
    f0 = framesDone;
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (wrValid === 1'b1 && wrAddr === AW'(3)) got = 1'b1;
      else cycles(1);
    end
    ready = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL simul_reach_addr3: got no write of addr 3 expected one within 2000 cycles");
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycles(1);
      if (engPhase == 1 && engCnt == 1) got = 1'b1;
    end
    ready = 1'b1;
    cycles(1);
    vectors++;
    if (!got || done !== 1'b1 || ox !== 16'sd1 || oy !== 16'sd1 || wrValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL simul_accept: got armed=%b done=%b x=%0d y=%0d valid=%b expected done=1 x=1 y=1 valid=0",
               got, done, ox, oy, wrValid);
    end
    cycles(1);
    vectors++;
    if (wrValid !== 1'b1 || wrAddr !== AW'(4)) begin
      miscompares++;
      $display("[TB] FAIL simul_latency: got valid=%b addr=%0d expected valid=1 addr=4", wrValid, wrAddr);
    end
    pulseStart();
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (frameDone === 1'b1) got = 1'b1;
      else cycles(1);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL simul_frame_timeout: got no frame_done expected one within 2000 cycles");
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (busy !== 1'b0 || wrValid !== 1'b0) bad++;
    end
    vectors++;
    if (writesTotal - w0 != NPIX || framesDone - f0 != 1 || bad != 0) begin
      miscompares++;
      $display("[TB] FAIL simul_start_ignored: got writes=%0d frames=%0d busy_cycles=%0d expected writes=%0d frames=1 busy_cycles=0",
               writesTotal - w0, framesDone - f0, bad, NPIX);
    end
    engMinLat = 2;
    engMaxLat = 5;
  endtask

  // Line wrap after (3,0) and frame wrap after (3,2).
  task automatic test_wrap();
    bit got;
    int wraps;
    int prevX;
    int prevY;
    bit prevBusy;
    int expX;
    int expY;
    colourSeed = 9;
    ready      = 1'b1;
    wraps      = 0;
    pulseStart();
    prevX    = int'(ox);
    prevY    = int'(oy);
    prevBusy = busy;
    got      = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      cycles(1);
      if (done === 1'b1 && prevBusy && prevX == H - 1 && (prevY == 0 || prevY == V - 1)) begin
        expX = 0;
        expY = (prevY == V - 1) ? 0 : prevY + 1;
        wraps++;
        vectors++;
        if (ox !== 16'(expX) || oy !== 16'(expY) || busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL wrap_from_%0d_%0d: got x=%0d y=%0d busy=%b expected x=%0d y=%0d busy=1",
                   prevX, prevY, ox, oy, busy, expX, expY);
        end
      end
      if (frameDone === 1'b1) got = 1'b1;
      prevX    = int'(ox);
      prevY    = int'(oy);
      prevBusy = busy;
    end
    vectors++;
    if (!got || wraps != 2) begin
      miscompares++;
      $display("[TB] FAIL wrap_events: got frame=%b wraps=%0d expected frame=1 wraps=2", got, wraps);
    end
    cycles(2);
  endtask

  // Random framebuffer readiness and engine latency over two frames.
  task automatic test_random_backpressure();
    bit got;
    int w0;
    engMinLat = 2;
    engMaxLat = 6;
    for (int f = 0; f < 2; f++) begin
      colourSeed = int'($urandom_range(255, 0));
      w0    = writesTotal;
      ready = 1'(($urandom) % 2);
      pulseStart();
      got = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
        if (frameDone === 1'b1) got = 1'b1;
        else begin
          ready = 1'(($urandom) % 2);
          cycles(1);
        end
      end
      ready = 1'b1;
      vectors++;
      if (!got) begin
        miscompares++;
        $display("[TB] FAIL random_frame_timeout: got no frame_done in frame %0d expected one within 5000 cycles", f);
      end
      cycles(2);
      vectors++;
      if (writesTotal - w0 != NPIX) begin
        miscompares++;
        $display("[TB] FAIL random_write_count: got %0d writes in frame %0d expected %0d", writesTotal - w0, f, NPIX);
      end
    end
    engMinLat = 2;
    engMaxLat = 5;
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    red   = 8'd0;
    green = 8'd0;
    blue  = 8'd0;
    fork
      engineLoop();
      monitorLoop();
    join_none
    test_reset();
    test_full_frame();
    test_flush();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_random_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
